// File: rtl/z80pio_multi.sv
// z80pio_multi: Z80-PIO-style parallel I/O controller with up to four 8-bit ports.
// Each port has a mode (output / input / bit-control), a per-bit direction and an
// interrupt mask, and a mode-2 vector. Pending interrupts are served lowest port first.
// Ports:
//   sys_clock, RESET   clock, synchronous active-high reset
//   ena                CPU clock enable; bus strobes are sampled only when ena=1
//   cs_n, addr         chip select; addr[PSEL_W-1:0] port index, addr[PSEL_W] 1 = control
//   iorq_n, rd_n, wr_n, m1_n   Z80 bus strobes (active low)
//   din / dout         CPU write data / registered read data or interrupt vector
//   int_n              registered interrupt request (active low)
//   port_in            asynchronous pin inputs, 8 bits per port
//   port_out, port_oe  output registers and per-bit output enables (1 = driving)
module z80pio_multi #(
    parameter int          NUM_PORTS = 2,
    parameter int          PSEL_W    = 1,
    parameter logic [31:0] RESET_OUT = 32'h0000_0100
) (
    input  logic                   sys_clock,
    input  logic                   RESET,
    input  logic                   ena,
    input  logic                   cs_n,
    input  logic [PSEL_W:0]        addr,
    input  logic                   iorq_n,
    input  logic                   rd_n,
    input  logic                   wr_n,
    input  logic                   m1_n,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   int_n,
    input  logic [8*NUM_PORTS-1:0] port_in,
    output logic [8*NUM_PORTS-1:0] port_out,
    output logic [8*NUM_PORTS-1:0] port_oe
);

    typedef enum logic [1:0] {CFG_IDLE = 2'd0, CFG_EXP_DIR = 2'd1, CFG_EXP_MASK = 2'd2} cfg_e;

    // Mode encoding as stored; a requested 2'b10 is folded into INPUT.
    localparam logic [1:0] MODE_OUT = 2'b00;
    localparam logic [1:0] MODE_IN  = 2'b01;
    localparam logic [1:0] MODE_BIT = 2'b11;

    localparam int PW = 8 * NUM_PORTS;

    logic [PW-1:0] sin_meta_q, sin_q, sin_prev_q;
    logic          wr_prev_q, ack_prev_q;
    logic [7:0]    dout_q;
    logic          int_n_q;

    cfg_e       cfg_q   [NUM_PORTS];
    cfg_e       cfg_d   [NUM_PORTS];
    logic [1:0] mode_q  [NUM_PORTS];
    logic [1:0] mode_d  [NUM_PORTS];
    logic [7:0] dir_q   [NUM_PORTS];
    logic [7:0] dir_d   [NUM_PORTS];
    logic [7:0] mask_q  [NUM_PORTS];
    logic [7:0] mask_d  [NUM_PORTS];
    logic [7:0] vec_q   [NUM_PORTS];
    logic [7:0] vec_d   [NUM_PORTS];
    logic [7:0] pout_q  [NUM_PORTS];
    logic [7:0] pout_d  [NUM_PORTS];
    logic [NUM_PORTS-1:0] ie_q, ie_d, andor_q, andor_d, hilo_q, hilo_d;
    logic [NUM_PORTS-1:0] pend_q, pend_d, cond_prev_q;
    logic [NUM_PORTS-1:0] cond_s, set_s;

    logic [PSEL_W-1:0] port_sel_s;
    logic              is_ctl_s;
    logic              wr_act_s, rd_act_s, ack_act_s;
    logic              wr_commit_s, ack_fire_s;
    logic              ack_hit_s, irq_s;
    logic [PSEL_W-1:0] ack_idx_s;
    logic [7:0]        ack_vec_s, rd_data_s;

    assign port_sel_s  = addr[PSEL_W-1:0];
    assign is_ctl_s    = addr[PSEL_W];
    assign wr_act_s    = ~cs_n & ~iorq_n & ~wr_n & m1_n;
    assign rd_act_s    = ~cs_n & ~iorq_n & ~rd_n;
    assign ack_act_s   = ~m1_n & ~iorq_n;
    // One commit / one acknowledge per bus cycle, however long WAIT stretches it.
    assign wr_commit_s = ena & wr_act_s & ~wr_prev_q;
    assign ack_fire_s  = ena & ack_act_s & ~ack_prev_q;

    assign dout  = dout_q;
    assign int_n = int_n_q;

    // Per-port interrupt conditions, pin drive, read mux and acknowledge priority.
    always_comb begin
        logic [7:0] s_v, lvl_v;
        cond_s    = '0;
        set_s     = '0;
        port_out  = '0;
        port_oe   = '0;
        rd_data_s = 8'hFF;
        ack_hit_s = 1'b0;
        ack_idx_s = '0;
        ack_vec_s = 8'hFF;
        irq_s     = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            s_v   = sin_q[p*8 +: 8];
            lvl_v = hilo_q[p] ? s_v : ~s_v;
            case (mode_q[p])
                MODE_IN:  cond_s[p] = |(s_v ^ sin_prev_q[p*8 +: 8]);
                MODE_BIT: cond_s[p] = andor_q[p] ? (~&mask_q[p] & &(lvl_v | mask_q[p]))
                                                 : |(lvl_v & ~mask_q[p]);
                default:  cond_s[p] = 1'b0;
            endcase
            // In INPUT mode every change counts; bit-control needs a rising condition.
            set_s[p] = (mode_q[p] == MODE_IN) ? cond_s[p] : (cond_s[p] & ~cond_prev_q[p]);

            port_out[p*8 +: 8] = pout_q[p];
            case (mode_q[p])
                MODE_OUT: port_oe[p*8 +: 8] = 8'hFF;
                MODE_BIT: port_oe[p*8 +: 8] = ~dir_q[p];
                default:  port_oe[p*8 +: 8] = 8'h00;
            endcase

            if (port_sel_s == PSEL_W'(p)) begin
                if (is_ctl_s) begin
                    rd_data_s = {ie_q[p], pend_q[p], 4'b0000, mode_q[p]};
                end else begin
                    case (mode_q[p])
                        MODE_OUT: rd_data_s = pout_q[p];
                        MODE_BIT: rd_data_s = (s_v & dir_q[p]) | (pout_q[p] & ~dir_q[p]);
                        default:  rd_data_s = s_v;
                    endcase
                end
            end else begin
                rd_data_s = rd_data_s;
            end
            irq_s = irq_s | (pend_q[p] & ie_q[p]);
        end
        // Walk downwards so the lowest requesting port ends up selected.
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (pend_q[p] & ie_q[p]) begin
                ack_hit_s = 1'b1;
                ack_idx_s = PSEL_W'(p);
                ack_vec_s = vec_q[p];
            end else begin
                ack_hit_s = ack_hit_s;
            end
        end
    end

    // Next-state of the per-port configuration FSM, registers and pending flags.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            cfg_d[p]   = cfg_q[p];
            mode_d[p]  = mode_q[p];
            dir_d[p]   = dir_q[p];
            mask_d[p]  = mask_q[p];
            vec_d[p]   = vec_q[p];
            pout_d[p]  = pout_q[p];
            ie_d[p]    = ie_q[p];
            andor_d[p] = andor_q[p];
            hilo_d[p]  = hilo_q[p];
            pend_d[p]  = pend_q[p];
            if (wr_commit_s && (port_sel_s == PSEL_W'(p))) begin
                if (is_ctl_s) begin
                    case (cfg_q[p])
                        CFG_IDLE: begin
                            if (din[0] == 1'b0) begin
                                vec_d[p] = {din[7:1], 1'b0};
                            end else if (din[3:0] == 4'hF) begin
                                case (din[7:6])
                                    2'b00:   mode_d[p] = MODE_OUT;
                                    2'b11:   mode_d[p] = MODE_BIT;
                                    default: mode_d[p] = MODE_IN;
                                endcase
                                cfg_d[p] = (din[7:6] == 2'b11) ? CFG_EXP_DIR : CFG_IDLE;
                            end else if (din[3:0] == 4'h7) begin
                                ie_d[p]    = din[7];
                                andor_d[p] = din[6];
                                hilo_d[p]  = din[5];
                                pend_d[p]  = 1'b0;
                                cfg_d[p]   = din[4] ? CFG_EXP_MASK : CFG_IDLE;
                            end else if (din[3:0] == 4'h3) begin
                                ie_d[p] = din[7];
                            end else begin
                                cfg_d[p] = CFG_IDLE;
                            end
                        end
                        CFG_EXP_DIR: begin
                            dir_d[p] = din;
                            cfg_d[p] = CFG_IDLE;
                        end
                        CFG_EXP_MASK: begin
                            mask_d[p] = din;
                            cfg_d[p]  = CFG_IDLE;
                        end
                        default: cfg_d[p] = CFG_IDLE;
                    endcase
                end else begin
                    pout_d[p] = din;
                end
            end else begin
                cfg_d[p] = cfg_q[p];
            end
            if (ack_fire_s && ack_hit_s && (ack_idx_s == PSEL_W'(p))) begin
                pend_d[p] = 1'b0;
            end else begin
                pend_d[p] = pend_d[p];
            end
            // A new condition wins over a same-cycle acknowledge or clear.
            if (set_s[p]) begin
                pend_d[p] = 1'b1;
            end else begin
                pend_d[p] = pend_d[p];
            end
        end
    end

    // State registers.
    always_ff @(posedge sys_clock) begin
        sin_meta_q <= port_in;
        sin_q      <= sin_meta_q;
        sin_prev_q <= sin_q;
        if (RESET) begin
            sin_meta_q  <= '0;
            sin_q       <= '0;
            sin_prev_q  <= '0;
            wr_prev_q   <= 1'b0;
            ack_prev_q  <= 1'b0;
            dout_q      <= 8'h00;
            int_n_q     <= 1'b1;
            ie_q        <= '0;
            andor_q     <= '0;
            hilo_q      <= '0;
            pend_q      <= '0;
            cond_prev_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cfg_q[p]  <= CFG_IDLE;
                mode_q[p] <= MODE_OUT;
                dir_q[p]  <= 8'h00;
                mask_q[p] <= 8'hFF;
                vec_q[p]  <= 8'h00;
                pout_q[p] <= RESET_OUT[p*8 +: 8];
            end
        end else begin
            if (ena) begin
                wr_prev_q  <= wr_act_s;
                ack_prev_q <= ack_act_s;
            end
            if (ack_fire_s) begin
                dout_q <= ack_hit_s ? ack_vec_s : 8'hFF;
            end else if (ena && rd_act_s) begin
                dout_q <= rd_data_s;
            end
            int_n_q     <= ~irq_s;
            ie_q        <= ie_d;
            andor_q     <= andor_d;
            hilo_q      <= hilo_d;
            pend_q      <= pend_d;
            cond_prev_q <= cond_s;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cfg_q[p]  <= cfg_d[p];
                mode_q[p] <= mode_d[p];
                dir_q[p]  <= dir_d[p];
                mask_q[p] <= mask_d[p];
                vec_q[p]  <= vec_d[p];
                pout_q[p] <= pout_d[p];
            end
        end
    end

endmodule

// File: tb/tb_z80pio_multi.sv
module tb_z80pio_multi;

    logic        sys_clock = 1'b0;
    logic        RESET;
    logic        ena;
    logic        cs_n, iorq_n, rd_n, wr_n, m1_n;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        int_n;
    logic [15:0] port_in;
    logic [15:0] port_out;
    logic [15:0] port_oe;

    int n_checks = 0;
    int n_errors = 0;

    z80pio_multi #(.NUM_PORTS(2), .PSEL_W(1), .RESET_OUT(32'h0000_0100)) dut (
        .sys_clock(sys_clock), .RESET(RESET), .ena(ena), .cs_n(cs_n), .addr(addr),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .din(din),
        .dout(dout), .int_n(int_n), .port_in(port_in), .port_out(port_out),
        .port_oe(port_oe)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Write held for six cycles to exercise the single-commit rule.
    task automatic bus_wr(input logic ctl, input logic p, input logic [7:0] d);
        @(negedge sys_clock);
        addr = {ctl, p}; din = d; cs_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (6) @(negedge sys_clock);
        cs_n = 1'b1; iorq_n = 1'b1; wr_n = 1'b1;
        @(negedge sys_clock);
    endtask

    task automatic bus_rd(input logic ctl, input logic p, output logic [7:0] d);
        @(negedge sys_clock);
        addr = {ctl, p}; cs_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
        repeat (2) @(negedge sys_clock);
        d = dout;
        cs_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
        @(negedge sys_clock);
    endtask

    task automatic bus_ack(output logic [7:0] d);
        @(negedge sys_clock);
        m1_n = 1'b0; iorq_n = 1'b0;
        repeat (2) @(negedge sys_clock);
        d = dout;
        m1_n = 1'b1; iorq_n = 1'b1;
        @(negedge sys_clock);
    endtask

    initial begin
        logic [7:0] rd;
        int lat;
        RESET = 1'b1; ena = 1'b1; cs_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
        wr_n = 1'b1; m1_n = 1'b1; addr = 2'b00; din = 8'h00; port_in = 16'h0000;
        repeat (3) @(negedge sys_clock);
        RESET = 1'b0;
        @(negedge sys_clock);

        // Reset state
        check_eq("rst_dout", dout, 8'h00);
        check_eq("rst_int_n", int_n, 1'b1);
        check_eq("rst_oe", port_oe, 16'hFFFF);
        check_eq("rst_out", port_out, 16'h0100);
        bus_rd(1'b0, 1'b0, rd); check_eq("rd_p0", rd, 8'h00);
        bus_rd(1'b0, 1'b1, rd); check_eq("rd_p1", rd, 8'h01);

        // Held data write, control read
        bus_wr(1'b0, 1'b0, 8'hA5);
        check_eq("wr_p0", port_out[7:0], 8'hA5);
        bus_rd(1'b1, 1'b0, rd); check_eq("ctl_p0", rd, 8'h00);

        // Bit-control mode on port 1 (held CF would corrupt dir if committed twice)
        port_in[15:8] = 8'h03;
        bus_wr(1'b1, 1'b1, 8'hCF);
        bus_wr(1'b1, 1'b1, 8'h0F);
        check_eq("bit_oe", port_oe[15:8], 8'hF0);
        bus_wr(1'b0, 1'b1, 8'h50);
        bus_rd(1'b0, 1'b1, rd); check_eq("bit_rd", rd, 8'h53);
        bus_rd(1'b1, 1'b1, rd); check_eq("bit_ctl", rd, 8'h03);

        // Interrupt from pin 0 of port 1
        port_in[15:8] = 8'h00;
        repeat (3) @(negedge sys_clock);
        bus_wr(1'b1, 1'b1, 8'h20);
        bus_wr(1'b1, 1'b1, 8'hB7);
        bus_wr(1'b1, 1'b1, 8'hFE);
        check_eq("irq_idle", int_n, 1'b1);
        bus_rd(1'b1, 1'b1, rd); check_eq("irq_ctl0", rd, 8'h83);
        port_in[8] = 1'b1;
        lat = 0;
        while (int_n !== 1'b0 && lat < 10) begin
            @(negedge sys_clock);
            lat++;
        end
        check_eq("irq_lat", (lat >= 3 && lat <= 4), 1'b1);
        bus_rd(1'b1, 1'b1, rd); check_eq("irq_ctl1", rd, 8'hC3);
        bus_ack(rd); check_eq("ack_vec", rd, 8'h20);
        repeat (2) @(negedge sys_clock);
        check_eq("ack_int_n", int_n, 1'b1);

        // Two ports pending: port 0 input-change, port 1 bit-control
        bus_wr(1'b1, 1'b0, 8'h10);
        bus_wr(1'b1, 1'b0, 8'h4F);
        bus_wr(1'b1, 1'b0, 8'h87);
        check_eq("in_oe", port_oe[7:0], 8'h00);
        port_in[8] = 1'b0;
        repeat (4) @(negedge sys_clock);
        port_in[8] = 1'b1; port_in[0] = 1'b1;
        repeat (6) @(negedge sys_clock);
        check_eq("two_int_n", int_n, 1'b0);
        bus_rd(1'b1, 1'b0, rd); check_eq("two_ctl0", rd, 8'hC1);
        bus_ack(rd); check_eq("two_ack0", rd, 8'h10);
        check_eq("two_int_n1", int_n, 1'b0);
        bus_ack(rd); check_eq("two_ack1", rd, 8'h20);
        repeat (2) @(negedge sys_clock);
        check_eq("two_int_n2", int_n, 1'b1);

        // Reset in the middle of a bit-control configuration
        bus_wr(1'b1, 1'b0, 8'hCF);
        @(negedge sys_clock); RESET = 1'b1;
        @(negedge sys_clock); RESET = 1'b0;
        bus_wr(1'b1, 1'b0, 8'h55);
        bus_rd(1'b1, 1'b0, rd); check_eq("mid_ctl", rd, 8'h00);
        check_eq("mid_oe", port_oe[7:0], 8'hFF);
        check_eq("mid_out", port_out, 16'h0100);
        bus_wr(1'b1, 1'b0, 8'hCF);
        bus_wr(1'b1, 1'b0, 8'h0F);
        check_eq("mid_dir", port_oe[7:0], 8'hF0);

        // No requester: acknowledge returns FF
        bus_ack(rd); check_eq("ack_none", rd, 8'hFF);

        // Writes are ignored while ena is low
        ena = 1'b0;
        bus_wr(1'b0, 1'b1, 8'h77);
        ena = 1'b1;
        @(negedge sys_clock);
        check_eq("ena_off", port_out[15:8], 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/z80pio_multi.md
Name: z80pio_multi

Overview:
- Parametrised Z80-PIO-style parallel I/O controller for the LM80C core. Replaces the two write-only port latches with up to four 8-bit ports.
- Each port has its own mode (output, input, bit-control), a per-bit direction mask and a Z80 mode-2 interrupt vector.
- Interrupts are prioritised across ports.
- Sits on the CPU I/O bus beside the CTC. Its dout is muxed into cpu_din by the top-level decoder, for both I/O reads and the IORQ&M1 vector cycle.

Parameters:
- NUM_PORTS, 2, number of ports (1..4).
- PSEL_W, 1, port-select address bits; must equal ceil(log2(NUM_PORTS)), minimum 1.
- RESET_OUT, 32'h0000_0100, reset value of the output registers, 8 bits per port, port 0 in [7:0]. The default gives port B = 1 (ROM enabled at boot).

Ports:
- sys_clock  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- ena  in  1  CPU clock enable; bus strobes are sampled only when ena=1.
- cs_n  in  1  chip select, active low.
- addr  in  PSEL_W+1  [PSEL_W-1:0] = port index, [PSEL_W] = 0 data / 1 control.
- iorq_n, rd_n, wr_n, m1_n  in  1 each  Z80 bus strobes, active low.
- din  in  8  CPU write data.
- dout  out  8  read data or interrupt vector, registered.
- int_n  out  1  interrupt request, active low.
- port_in  in  8*NUM_PORTS  external pin inputs, asynchronous.
- port_out  out  8*NUM_PORTS  output registers.
- port_oe  out  8*NUM_PORTS  per-bit output enable; 1 = driving.

Behaviour:
- Reset state:
  - port_out = RESET_OUT; mode = OUTPUT; dir = 8'h00; mask = 8'hFF; ie = 0; vector = 0.
  - pending = 0; cfg state = IDLE; int_n = 1; dout = 0.
  - Reset mid-sequence aborts any pending DIR/MASK expectation.
- Input synchronisation: port_in passes through a 2-flop synchroniser on sys_clock, not gated by ena. Call the result sin.
- Write strobe: wr_act = ~cs_n & ~iorq_n & ~wr_n & m1_n.
  - A write commits on the first ena cycle where wr_act is true and was false on the previous ena cycle.
  - Exactly one commit per bus cycle, however long WAIT stretches it.
- Data write: port_out[p] <= din in every mode; the pins show it only where port_oe=1.
- Control write, per-port cfg FSM:
  - IDLE, din[0]=0: vector[p] <= {din[7:1],1'b0}.
  - IDLE, din[3:0]=4'hF: mode <= din[7:6]. 00 OUTPUT, 01 INPUT, 10 treated as INPUT, 11 BITCTL. If 11, go to EXP_DIR.
  - IDLE, din[3:0]=4'h7: ie <= din[7]; andor <= din[6] (1 = AND); hilo <= din[5] (1 = high active). If din[4], go to EXP_MASK. Clears pending.
  - IDLE, din[3:0]=4'h3: ie <= din[7].
  - IDLE, any other value: ignored.
  - EXP_DIR: dir <= din (1 = input bit); go to IDLE.
  - EXP_MASK: mask <= din (0 = monitored); go to IDLE.
- port_oe:
  - OUTPUT: 8'hFF.
  - INPUT: 8'h00.
  - BITCTL: ~dir.
- Data read (~cs_n & ~iorq_n & ~rd_n):
  - OUTPUT: dout <= port_out.
  - INPUT: dout <= sin.
  - BITCTL: dout <= (sin & dir) | (port_out & ~dir).
- Control read: dout <= {ie, pending, 4'b0, mode}.
- Unselected, non-ack cycles: dout holds its last value.
- Interrupt condition per port:
  - INPUT: sin differs from its value on the previous sys_clock.
  - BITCTL: reduce over monitored bits of (hilo ? sin : ~sin). AND if andor=1, else OR. Zero monitored bits = false.
  - A false->true transition of the reduced value sets pending.
  - OUTPUT: never.
- int_n = ~|(pending & ie), registered; 1-cycle latency from pending set.
- Acknowledge: ~m1_n & ~iorq_n, on its first ena cycle.
  - dout <= vector of the lowest-index port with pending & ie; that port's pending clears.
  - A second port still pending keeps int_n low.
  - No requester: dout <= 8'hFF.
- Simultaneous events:
  - An acknowledge in the same cycle as a new condition on the acknowledged port: set wins and pending stays 1.
  - A control write and a data write on the same cycle cannot occur (single bus).
- No RETI decode and no daisy chain; in-service tracking is out of scope.

Test Plan:
- Reset, then data read of ports 0 and 1 -> dout=8'h00 then 8'h01; port_oe=16'hFFFF; int_n=1.
- Write 8'hA5 to data port 0 with wr held 6 ena cycles -> a single commit, port_out[7:0]=A5. Control read of port 0 -> dout=8'h00.
- Control writes 8'hCF then 8'h0F to port 1 -> mode BITCTL, dir=0F, port_oe[15:8]=F0. With sin=8'h03 and port_out=8'h50, a data read returns 8'h53.
- Port 1 in BITCTL, writes 8'h20 (vector), 8'hB7, mask 8'hFE. Drive pin 0 high -> int_n low 3-4 clocks later. Acknowledge -> dout=8'h20, int_n=1.
- Ports 0 and 1 both pending and enabled, vectors 10/20 -> first ack returns 10 with int_n still 0; second ack returns 20, then int_n=1.
- Write 8'hCF to port 0, assert RESET for one clock, then write 8'h55 to control -> treated as IDLE and ignored. Mode=OUTPUT, dir=00.
